// File: rtl/game_pkg.sv
// game_pkg: status encodings and width helpers shared by the game-progress controller
package game_pkg;
    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_PLAYING   = 3'd1,
        ST_LEVEL_INC = 3'd2,
        ST_WORLD_INC = 3'd3,
        ST_LIFE_LOST = 3'd4,
        ST_LOSE      = 3'd5,
        ST_WIN       = 3'd6
    } gameState_t;
    localparam logic [1:0] PS_PLAY = 2'd0;
    localparam logic [1:0] PS_PASS = 2'd1;
    localparam logic [1:0] PS_DIED = 2'd2;
    localparam int LEVEL_W = 3;
    function automatic int widthOf(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rising_edge_detect.sv
// rising_edge_detect: one-cycle pulse on the rising edge of a debounced level
module rising_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);
    logic sigQ;
    always_ff @(posedge clk) sigQ <= rst ? 1'b0 : sig;
    assign rise = sig & ~sigQ;
endmodule

// File: rtl/game_progress_fsm.sv
// game_progress_fsm: sequences start, level/world advance, life loss, bonus lives and win/lose
module game_progress_fsm
    import game_pkg::*;
#(
    parameter int NUM_LEVELS  = 4,
    parameter int NUM_WORLDS  = 3,
    parameter int START_LIVES = 3,
    parameter int MAX_LIVES   = 7,
    parameter int BONUS_EVERY = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_btn,
    input  logic [1:0]                         player_status,
    output logic [2:0]                         game_status,
    output logic [widthOf(NUM_WORLDS)-1:0]     world,
    output logic [LEVEL_W-1:0]                 level,
    output logic [widthOf(MAX_LIVES+1)-1:0]    lives,
    output logic                               level_load,
    output logic                               busy
);
    localparam int WorldW   = widthOf(NUM_WORLDS);
    localparam int LivesW   = widthOf(MAX_LIVES + 1);
    localparam int HoldW    = widthOf(HOLD_CYCLES);
    localparam int BonusW   = widthOf(BONUS_EVERY);
    localparam int BonusTop = (BONUS_EVERY > 0) ? BONUS_EVERY - 1 : 0;

    gameState_t        state;
    logic [HoldW-1:0]  holdCnt;
    logic [BonusW-1:0] bonusCnt;
    logic [LivesW-1:0] livesUp;
    logic startRise, lastLevel, lastWorld, holdDone, bonusHit;

    rising_edge_detect startEdge (
        .clk  (clk),
        .rst  (rst),
        .sig  (start_btn),
        .rise (startRise)
    );

    assign lastLevel   = level == LEVEL_W'(NUM_LEVELS - 1);
    assign lastWorld   = world == WorldW'(NUM_WORLDS - 1);
    assign holdDone    = holdCnt >= HoldW'(HOLD_CYCLES - 1);
    assign bonusHit    = bonusCnt == BonusW'(BonusTop);
    assign livesUp     = (lives >= LivesW'(MAX_LIVES)) ? lives : lives + 1'b1;
    assign game_status = state;
    assign busy        = state inside {ST_LEVEL_INC, ST_WORLD_INC, ST_LIFE_LOST};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_START;
            world      <= '0;
            level      <= '0;
            lives      <= LivesW'(START_LIVES);
            level_load <= 1'b0;
            holdCnt    <= '0;
            bonusCnt   <= '0;
        end else begin
            level_load <= 1'b0;
            // Saturating so a long-held status never wraps the count
            holdCnt    <= busy ? (holdDone ? holdCnt : holdCnt + 1'b1) : '0;
            case (state)
                ST_START, ST_LOSE, ST_WIN: begin
                    if (startRise) begin
                        state      <= ST_PLAYING;
                        world      <= '0;
                        level      <= '0;
                        lives      <= LivesW'(START_LIVES);
                        bonusCnt   <= '0;
                        level_load <= 1'b1;
                    end
                end
                ST_PLAYING: begin
                    if (player_status == PS_PASS) begin
                        if (lastLevel && lastWorld) begin
                            state <= ST_WIN;
                        end else begin
                            state <= lastLevel ? ST_WORLD_INC : ST_LEVEL_INC;
                            world <= lastLevel ? world + 1'b1 : world;
                            level <= lastLevel ? '0 : level + 1'b1;
                            if (BONUS_EVERY > 0) begin
                                bonusCnt <= bonusHit ? '0 : bonusCnt + 1'b1;
                                if (bonusHit) lives <= livesUp;
                            end
                        end
                    end else if (player_status == PS_DIED) begin
                        state <= (lives <= LivesW'(1)) ? ST_LOSE : ST_LIFE_LOST;
                        lives <= (lives <= LivesW'(1)) ? '0 : lives - 1'b1;
                    end
                end
                ST_LEVEL_INC, ST_WORLD_INC, ST_LIFE_LOST: begin
                    if (holdDone && player_status == PS_PLAY) begin
                        state      <= ST_PLAYING;
                        level_load <= 1'b1;
                    end
                end
                default: state <= ST_START;
            endcase
        end
    end
endmodule

// File: tb/tb_game_progress_fsm.sv
// tb_game_progress_fsm: scoreboard bench; default DUT plus a MAX_LIVES=3 copy driven in lockstep
module tb_game_progress_fsm;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic startBtn = 1'b0;
    logic [1:0] playerStatus = 2'd0;
    logic [2:0] stA, stB, levelA, levelB, livesA;
    logic [1:0] worldA, worldB, livesB;
    logic loadA, loadB, busyA, busyB;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit monOn = 1'b0;

    typedef struct {
        int t;
        int st;
        int world;
        int level;
        int livesA;
        int livesB;
        int load;
    } snap_t;
    snap_t expQ[$];

    int pSt[12] = '{2, 2, 2, 3, 2, 2, 2, 3, 2, 2, 2, 6};
    int pW[12]  = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2};
    int pL[12]  = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 3};
    int pA[12]  = '{3, 3, 3, 4, 4, 4, 4, 5, 5, 5, 5, 5};
    int pB[12]  = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};

    game_progress_fsm dutA (
        .clk(clk), .rst(rst), .start_btn(startBtn), .player_status(playerStatus),
        .game_status(stA), .world(worldA), .level(levelA), .lives(livesA),
        .level_load(loadA), .busy(busyA)
    );

    game_progress_fsm #(.MAX_LIVES(3)) dutB (
        .clk(clk), .rst(rst), .start_btn(startBtn), .player_status(playerStatus),
        .game_status(stB), .world(worldB), .level(levelB), .lives(livesB),
        .level_load(loadB), .busy(busyB)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [24:0] packExp(input snap_t e);
        logic bz;
        bz = (e.st >= 2) && (e.st <= 4);
        return {3'(e.st), 3'(e.st), 2'(e.world), 2'(e.world), 3'(e.level), 3'(e.level),
                3'(e.livesA), 2'(e.livesB), 1'(e.load), 1'(e.load), bz, bz};
    endfunction

    task automatic push(input int t, input int st, input int w, input int l,
                        input int a, input int b, input int ld);
        snap_t e;
        e.t = t; e.st = st; e.world = w; e.level = l; e.livesA = a; e.livesB = b; e.load = ld;
        expQ.push_back(e);
    endtask

    // Monitor: every change of any DUT output is one event, matched against the next expectation
    logic [24:0] prevObs;
    bit prevValid = 1'b0;
    always @(negedge clk) begin
        logic [24:0] obs;
        snap_t e;
        obs = {stA, stB, worldA, worldB, levelA, levelB, livesA, livesB, loadA, loadB, busyA, busyB};
        if (monOn && (!prevValid || obs !== prevObs)) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%h", cyc, obs);
            end else begin
                e = expQ.pop_front();
                if (obs !== packExp(e) || (e.t >= 0 && e.t != cyc)) begin
                    errors++;
                    $display("FAIL snapshot cyc=%0d got=%h exp=%h exp_cyc=%0d", cyc, obs, packExp(e), e.t);
                end
            end
        end
        if (monOn) begin
            prevObs = obs;
            prevValid = 1'b1;
        end
    end

    task automatic doStart();
        int c;
        c = cyc;
        push(c + 1, 1, 0, 0, 3, 3, 1);
        push(c + 2, 1, 0, 0, 3, 3, 0);
        startBtn = 1'b1;
        repeat (4) @(negedge clk);
        startBtn = 1'b0;
        @(negedge clk);
    endtask

    // Drive a status for h cycles; transient states exit once held long enough and status is 0
    task automatic doAct(input logic [1:0] ps, input int st, input int w, input int l,
                         input int a, input int b, input int h);
        int c, ex;
        c = cyc;
        ex = (h + 1 > 3) ? c + h + 1 : c + 3;
        push(c + 1, st, w, l, a, b, 0);
        if (st != 5 && st != 6) begin
            push(ex, 1, w, l, a, b, 1);
            push(ex + 1, 1, w, l, a, b, 0);
        end
        playerStatus = ps;
        repeat (h) @(negedge clk);
        playerStatus = PS_PLAY;
        while (cyc < ex + 1) @(negedge clk);
    endtask

    initial begin
        int c;
        @(negedge clk);
        push(-1, 0, 0, 0, 3, 3, 0);
        monOn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        while (cyc < 5) @(negedge clk);
        doStart();
        for (int i = 0; i < 12; i++) doAct(PS_PASS, pSt[i], pW[i], pL[i], pA[i], pB[i], (i == 4) ? 10 : 1);
        doStart();
        doAct(PS_DIED, 4, 0, 0, 2, 2, 1);
        doAct(PS_DIED, 4, 0, 0, 1, 1, 1);
        doAct(PS_DIED, 5, 0, 0, 0, 0, 1);
        playerStatus = PS_PASS;
        repeat (2) @(negedge clk);
        playerStatus = PS_PLAY;
        @(negedge clk);
        doStart();
        for (int i = 0; i < 3; i++) doAct(PS_PASS, 2, 0, i + 1, 3, 3, 1);
        c = cyc;
        push(c + 1, 3, 1, 0, 4, 3, 0);
        push(c + 2, 0, 0, 0, 3, 3, 0);
        playerStatus = PS_PASS;
        @(negedge clk);
        playerStatus = PS_PLAY;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got=%0d exp=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (3000) @(posedge clk);
        errors++;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
